// File: rtl/timestamp_sync_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// timestamp_pkg
//   Shared types and constants for the timestamp offset synchroniser.
//   - ts_sync_state_e : controller state encoding (IDLE/ACQUIRE/TRACK/HOLDOVER)
//   - TS_LSB_W        : width of the timestamp / counter LSB slice
//   - STATS_W         : width of the statistics counters
//   - stats_sat_inc() : saturating increment used by the statistics counters
// -----------------------------------------------------------------------------
package timestamp_pkg;

    localparam int TS_LSB_W = 8;
    localparam int STATS_W  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACQUIRE  = 2'd1,
        TRACK    = 2'd2,
        HOLDOVER = 2'd3
    } ts_sync_state_e;

    function automatic logic [STATS_W-1:0] stats_sat_inc(input logic [STATS_W-1:0] v);
        return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ts_edge_timer.sv
// -----------------------------------------------------------------------------
// ts_edge_timer
//   Counts gt-clock edge strobes while enabled. tc is a combinational pulse on
//   the cycle that carries the PERIOD-th counted edge, so the owner can act on
//   it in the same cycle and register the result. The counter uses the minimum
//   width that holds PERIOD and sticks at PERIOD if the owner does not clear it.
//
//   Ports:
//     clk_128M : clock
//     rst_n    : asynchronous active-low reset
//     en       : count enable (timer is only meaningful while enabled)
//     clr      : synchronous clear, wins over counting
//     edge_in  : one-cycle strobe per recovered-clock edge
//     tc       : terminal-count pulse (PERIOD-th edge seen this cycle)
// -----------------------------------------------------------------------------
module ts_edge_timer #(
    parameter int PERIOD = 4096     // must be >= 1
) (
    input  logic clk_128M,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic edge_in,
    output logic tc
);

    localparam int                CNT_W = $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  TERM  = CNT_W'(PERIOD);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && edge_in && (count_q != TERM)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign tc = en && edge_in && (count_q == LAST);

    always_ff @(posedge clk_128M or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/timestamp_sync_ctrl.sv
// -----------------------------------------------------------------------------
// timestamp_sync_ctrl
//   Acquires and tracks the 8-bit offset between the DUT timestamp stream and
//   the local DUT-synchronous counter, so the downstream timestamp adder only
//   ever sees a vetted offset. Runs ACQUIRE (running max of deltas), TRACK
//   (windowed raises with outlier rejection and slow decay) and HOLDOVER
//   (offset frozen while the stream is silent). Gives the host a coherent
//   snapshot of offset and state.
//
//   Optional statistics: define TIMESTAMP_SYNC_STATS_EN to build the saturating
//   adjust/outlier counters; otherwise both stats ports read 0.
//
//   Ports:
//     clk_128M         : sole clock
//     rst_n            : asynchronous active-low reset
//     gt_clk_edge_128M : one-cycle strobe per recovered DUT clock edge
//     counter_lsb      : bits [7:0] of the local DUT-synchronous counter
//     timestamp_in     : timestamp from the serial stream
//     timestamp_valid  : qualifies timestamp_in
//     clear_req        : pulse, back to IDLE with offset 0
//     snapshot_req     : pulse, latch offset/state for the host
//     offset           : current offset for the counter adder
//     offset_adjust    : pulse on each sample-driven offset change
//     locked           : high only in TRACK
//     state            : IDLE=0 ACQUIRE=1 TRACK=2 HOLDOVER=3
//     snap_valid       : pulse the cycle after snapshot_req
//     snap_offset      : latched offset
//     snap_state       : latched state
//     adjust_count     : saturating count of offset_adjust pulses (stats)
//     outlier_count    : saturating count of rejected samples (stats)
// -----------------------------------------------------------------------------
module timestamp_sync_ctrl
    import timestamp_pkg::*;
#(
    parameter int ACQ_SAMPLES  = 16,       // 1..255
    parameter int JUMP_LIMIT   = 32,       // 0..255
    parameter int MAX_OUTLIERS = 3,        // >= 1
    parameter int DECAY_PERIOD = 1048576,  // >= 1
    parameter int LOSS_TIMEOUT = 4096      // >= 1
) (
    input  logic                clk_128M,
    input  logic                rst_n,
    input  logic                gt_clk_edge_128M,
    input  logic [TS_LSB_W-1:0] counter_lsb,
    input  logic [TS_LSB_W-1:0] timestamp_in,
    input  logic                timestamp_valid,
    input  logic                clear_req,
    input  logic                snapshot_req,
    output logic [TS_LSB_W-1:0] offset,
    output logic                offset_adjust,
    output logic                locked,
    output logic [1:0]          state,
    output logic                snap_valid,
    output logic [TS_LSB_W-1:0] snap_offset,
    output logic [1:0]          snap_state,
    output logic [STATS_W-1:0]  adjust_count,
    output logic [STATS_W-1:0]  outlier_count
);

    localparam int              RUN_W   = $clog2(MAX_OUTLIERS + 1);
    localparam logic [RUN_W:0]  RUN_MAX = (RUN_W + 1)'(MAX_OUTLIERS);
    localparam logic [8:0]      JUMP_9  = 9'(JUMP_LIMIT);
    localparam logic [8:0]      ACQ_TGT = 9'(ACQ_SAMPLES);

    // Registered state and outputs
    ts_sync_state_e      state_q,      state_d;
    logic [TS_LSB_W-1:0] offset_q,     offset_d;
    logic                adjust_q,     adjust_d;
    logic                locked_q,     locked_d;
    logic [7:0]          acq_cnt_q,    acq_cnt_d;
    logic [RUN_W-1:0]    run_q,        run_d;
    logic                snap_valid_q;
    logic [TS_LSB_W-1:0] snap_offset_q;
    logic [1:0]          snap_state_q;

    // Combinational helpers
    logic [TS_LSB_W-1:0] delta;
    logic [8:0]          win_top;
    logic [8:0]          acq_next;
    logic [RUN_W:0]      run_next;
    logic                raise_evt;

    // Timer interface
    logic decay_en, decay_clr, decay_tc;
    logic loss_en,  loss_clr,  loss_tc;

    // Plain modular difference; the offset is an unsigned lead of the local
    // counter over the stream timestamp.
    assign delta   = counter_lsb - timestamp_in;
    // Upper edge of the tracking window in 9 bits so offset+JUMP_LIMIT cannot wrap.
    assign win_top = {1'b0, offset_q} + JUMP_9;

    // -------------------------------------------------------------------------
    // Next-state logic. Priority: clear_req > loss timeout > sample > decay.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        adjust_d  = 1'b0;
        acq_cnt_d = acq_cnt_q;
        run_d     = run_q;
        acq_next  = 9'd0;
        run_next  = '0;
        raise_evt = 1'b0;

        if (clear_req) begin
            state_d   = IDLE;
            offset_d  = '0;
            acq_cnt_d = '0;
            run_d     = '0;
        end else if (loss_tc) begin
            // Stream went quiet: freeze offset, drop lock, forget partial runs.
            state_d   = HOLDOVER;
            acq_cnt_d = '0;
            run_d     = '0;
        end else begin
            if (timestamp_valid) begin
                if (state_q == TRACK) begin
                    if (delta <= offset_q) begin
                        run_d = '0;
                    end else if ({1'b0, delta} <= win_top) begin
                        offset_d  = delta;
                        run_d     = '0;
                        raise_evt = 1'b1;
                    end else begin
                        run_next = {1'b0, run_q} + 1'b1;
                        if (run_next == RUN_MAX) begin
                            // Too many consecutive jumps: the offset is stale.
                            state_d   = ACQUIRE;
                            offset_d  = '0;
                            run_d     = '0;
                            acq_cnt_d = '0;
                        end else begin
                            run_d = run_next[RUN_W-1:0];
                        end
                    end
                end else begin
                    // IDLE and HOLDOVER enter ACQUIRE with this as sample 1;
                    // HOLDOVER keeps its offset as the starting max.
                    acq_next = (state_q == ACQUIRE) ? ({1'b0, acq_cnt_q} + 9'd1) : 9'd1;
                    if (delta > offset_q) begin
                        offset_d = delta;
                    end
                    if (acq_next == ACQ_TGT) begin
                        state_d   = TRACK;
                        acq_cnt_d = '0;
                    end else begin
                        state_d   = ACQUIRE;
                        acq_cnt_d = acq_next[7:0];
                    end
                end
            end

            // Only sample-driven changes reach this point, so this is the pulse.
            adjust_d = (offset_d != offset_q);

            // Decay yields to any sample-driven change in the same cycle.
            // decay_tc can only fire in TRACK.
            if (decay_tc && !adjust_d && (offset_q != '0)) begin
                offset_d = offset_q - 8'd1;
            end
        end

        locked_d = (state_d == TRACK);
    end

    // -------------------------------------------------------------------------
    // Timers
    // -------------------------------------------------------------------------
    assign decay_en  = (state_q == TRACK);
    assign decay_clr = clear_req || !decay_en || decay_tc || raise_evt;

    assign loss_en   = (state_q == ACQUIRE) || (state_q == TRACK);
    assign loss_clr  = clear_req || timestamp_valid || !loss_en || loss_tc;

    ts_edge_timer #(
        .PERIOD (DECAY_PERIOD)
    ) u_decay_timer (
        .clk_128M (clk_128M),
        .rst_n    (rst_n),
        .en       (decay_en),
        .clr      (decay_clr),
        .edge_in  (gt_clk_edge_128M),
        .tc       (decay_tc)
    );

    ts_edge_timer #(
        .PERIOD (LOSS_TIMEOUT)
    ) u_loss_timer (
        .clk_128M (clk_128M),
        .rst_n    (rst_n),
        .en       (loss_en),
        .clr      (loss_clr),
        .edge_in  (gt_clk_edge_128M),
        .tc       (loss_tc)
    );

    // -------------------------------------------------------------------------
    // FSM and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_128M or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            offset_q      <= '0;
            adjust_q      <= 1'b0;
            locked_q      <= 1'b0;
            acq_cnt_q     <= '0;
            run_q         <= '0;
            snap_valid_q  <= 1'b0;
            snap_offset_q <= '0;
            snap_state_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            adjust_q     <= adjust_d;
            locked_q     <= locked_d;
            acq_cnt_q    <= acq_cnt_d;
            run_q        <= run_d;
            snap_valid_q <= snapshot_req;
            // Snapshot captures the values visible to the host in the request
            // cycle, i.e. before this cycle's update.
            if (snapshot_req) begin
                snap_offset_q <= offset_q;
                snap_state_q  <= state_q;
            end
        end
    end

    assign offset        = offset_q;
    assign offset_adjust = adjust_q;
    assign locked        = locked_q;
    assign state         = state_q;
    assign snap_valid    = snap_valid_q;
    assign snap_offset   = snap_offset_q;
    assign snap_state    = snap_state_q;

    // -------------------------------------------------------------------------
    // Statistics
    // -------------------------------------------------------------------------
`ifdef TIMESTAMP_SYNC_STATS_EN
    logic               outlier_evt;
    logic [STATS_W-1:0] adj_cnt_q;
    logic [STATS_W-1:0] out_cnt_q;

    // Every TRACK sample above the window is rejected, including the one that
    // forces re-acquisition.
    assign outlier_evt = !clear_req && !loss_tc && timestamp_valid &&
                         (state_q == TRACK) && ({1'b0, delta} > win_top);

    always_ff @(posedge clk_128M or negedge rst_n) begin
        if (!rst_n) begin
            adj_cnt_q <= '0;
            out_cnt_q <= '0;
        end else begin
            if (adjust_d) begin
                adj_cnt_q <= stats_sat_inc(adj_cnt_q);
            end
            if (outlier_evt) begin
                out_cnt_q <= stats_sat_inc(out_cnt_q);
            end
        end
    end

    assign adjust_count  = adj_cnt_q;
    assign outlier_count = out_cnt_q;
`else
    assign adjust_count  = '0;
    assign outlier_count = '0;
`endif

endmodule

// File: tb/tb_timestamp_sync_ctrl.sv
`timescale 1ns/1ps
module tb_timestamp_sync_ctrl;
    import timestamp_pkg::*;

    localparam int ACQ_N = 16;
    localparam int JUMP  = 32;
    localparam int MAXO  = 3;
    localparam int DECAY = 5000;   // shortened so decay fits in a short run
    localparam int LOSS  = 4096;

    logic        clk_128M = 1'b0;
    logic        rst_n    = 1'b0;
    logic        gt       = 1'b0;
    logic [7:0]  cnt_lsb  = 8'd0;
    logic [7:0]  ts_in    = 8'd0;
    logic        valid    = 1'b0;
    logic        clr      = 1'b0;
    logic        snap     = 1'b0;

    logic [7:0]  offset;
    logic        offset_adjust;
    logic        locked;
    logic [1:0]  state;
    logic        snap_valid;
    logic [7:0]  snap_offset;
    logic [1:0]  snap_state;
    logic [15:0] adjust_count;
    logic [15:0] outlier_count;

    timestamp_sync_ctrl #(
        .ACQ_SAMPLES  (ACQ_N),
        .JUMP_LIMIT   (JUMP),
        .MAX_OUTLIERS (MAXO),
        .DECAY_PERIOD (DECAY),
        .LOSS_TIMEOUT (LOSS)
    ) dut (
        .clk_128M         (clk_128M),
        .rst_n            (rst_n),
        .gt_clk_edge_128M (gt),
        .counter_lsb      (cnt_lsb),
        .timestamp_in     (ts_in),
        .timestamp_valid  (valid),
        .clear_req        (clr),
        .snapshot_req     (snap),
        .offset           (offset),
        .offset_adjust    (offset_adjust),
        .locked           (locked),
        .state            (state),
        .snap_valid       (snap_valid),
        .snap_offset      (snap_offset),
        .snap_state       (snap_state),
        .adjust_count     (adjust_count),
        .outlier_count    (outlier_count)
    );

    always #4 clk_128M = ~clk_128M;

    // ---------------------------------------------------------------- checking
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int adj_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    // --------------------------------------------------------------- scoreboard
    typedef struct {
        logic [7:0]  off;
        logic        adj;
        logic [1:0]  st;
        logic        lk;
        logic        sv;
        logic [7:0]  so;
        logic [1:0]  ss;
        logic [15:0] ac;
        logic [15:0] oc;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    int m_st, m_off, m_acq, m_run, m_dec, m_loss, m_so, m_ss, m_ac, m_oc;

    task automatic model_reset();
        m_st = 0; m_off = 0; m_acq = 0; m_run = 0; m_dec = 0; m_loss = 0;
        m_so = 0; m_ss = 0; m_ac = 0; m_oc = 0;
    endtask

    task automatic model_step(input bit g, input logic [7:0] c, input logic [7:0] t,
                              input bit v, input bit cl, input bit sn);
        int   d, n_st, n_off, acq, run;
        bit   loss_act, dec_act, loss_to, dec_to, raise, outl, adj;
        exp_t e;
        d        = (int'(c) - int'(t)) & 255;
        loss_act = (m_st == 1) || (m_st == 2);
        dec_act  = (m_st == 2);
        loss_to  = loss_act && g && (m_loss == LOSS - 1);
        dec_to   = dec_act && g && (m_dec == DECAY - 1);
        n_st = m_st; n_off = m_off; raise = 0; outl = 0; adj = 0;
        if (sn) begin m_so = m_off; m_ss = m_st; end
        if (cl) begin
            n_st = 0; n_off = 0; m_acq = 0; m_run = 0;
        end else if (loss_to) begin
            n_st = 3; m_acq = 0; m_run = 0;
        end else begin
            if (v) begin
                if (m_st == 2) begin
                    if (d <= m_off) m_run = 0;
                    else if (d <= m_off + JUMP) begin n_off = d; m_run = 0; raise = 1; end
                    else begin
                        outl = 1;
                        run  = m_run + 1;
                        if (run == MAXO) begin n_st = 1; n_off = 0; m_run = 0; m_acq = 0; end
                        else m_run = run;
                    end
                end else begin
                    acq = (m_st == 1) ? m_acq + 1 : 1;
                    if (d > m_off) n_off = d;
                    if (acq == ACQ_N) begin n_st = 2; m_acq = 0; end
                    else begin n_st = 1; m_acq = acq; end
                end
            end
            adj = (n_off != m_off);
            if (dec_to && !adj && m_off > 0) n_off = m_off - 1;
        end
        if (cl || !dec_act || dec_to || raise) m_dec = 0; else if (g) m_dec++;
        if (cl || v || !loss_act || loss_to) m_loss = 0; else if (g) m_loss++;
`ifdef TIMESTAMP_SYNC_STATS_EN
        if (adj && m_ac < 65535) m_ac++;
        if (outl && m_oc < 65535) m_oc++;
`endif
        m_st  = n_st;
        m_off = n_off;
        e.off = 8'(m_off); e.adj = adj; e.st = 2'(m_st); e.lk = (m_st == 2);
        e.sv  = sn; e.so = 8'(m_so); e.ss = 2'(m_ss);
        e.ac  = 16'(m_ac); e.oc = 16'(m_oc);
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val("offset",        32'(offset),        32'(e.off));
            check_val("offset_adjust", 32'(offset_adjust), 32'(e.adj));
            check_val("state",         32'(state),         32'(e.st));
            check_val("locked",        32'(locked),        32'(e.lk));
            check_val("snap_valid",    32'(snap_valid),    32'(e.sv));
            check_val("snap_offset",   32'(snap_offset),   32'(e.so));
            check_val("snap_state",    32'(snap_state),    32'(e.ss));
            check_val("adjust_count",  32'(adjust_count),  32'(e.ac));
            check_val("outlier_count", 32'(outlier_count), 32'(e.oc));
        end
        if (offset_adjust) adj_seen++;
    endtask

    // One clock of stimulus: drive, predict, advance, compare.
    task automatic drive_cycle(input bit g, input logic [7:0] c, input logic [7:0] t,
                               input bit v, input bit cl, input bit sn);
        gt = g; cnt_lsb = c; ts_in = t; valid = v; clr = cl; snap = sn;
        model_step(g, c, t, v, cl, sn);
        @(posedge clk_128M);
        #1;
        compare_out();
        if (v || cl || sn)
            $display("txn t=%0t valid=%0b clr=%0b snap=%0b delta=%0d -> state=%0d offset=%0d adj=%0b",
                     $time, v, cl, sn, 8'(c - t), state, offset, offset_adjust);
    endtask

    task automatic send(input int dlt, input bit g);
        logic [7:0] c;
        c = 8'($urandom_range(0, 255));
        drive_cycle(g, c, c - 8'(dlt), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic quiet(input int n, input bit g);
        for (int i = 0; i < n; i++) drive_cycle(g, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // ----------------------------------------------------------------- stimulus
    int acq_d[16] = '{5, 9, 7, 12, 3, 12, 1, 2, 4, 6, 8, 10, 11, 0, 12, 5};

    initial begin
        // Reset
        model_reset();
        repeat (2) @(posedge clk_128M);
        #1;
        check_val("rst_offset",      32'(offset),        32'd0);
        check_val("rst_adjust",      32'(offset_adjust), 32'd0);
        check_val("rst_state",       32'(state),         32'd0);
        check_val("rst_locked",      32'(locked),        32'd0);
        check_val("rst_snap_valid",  32'(snap_valid),    32'd0);
        check_val("rst_snap_offset", 32'(snap_offset),   32'd0);
        check_val("rst_adjust_cnt",  32'(adjust_count),  32'd0);
        check_val("rst_outlier_cnt", 32'(outlier_count), 32'd0);
        rst_n = 1'b1;
        quiet(2, 1'b0);

        // Acquisition: 16 samples, max 12, new max at 5, 9, 12
        adj_seen = 0;
        for (int i = 0; i < 16; i++) begin
            send(acq_d[i], 1'b0);
            if (i == 0) check_val("acq_first_state", 32'(state), 32'd1);
            if (i == 14) check_val("acq_pre_state", 32'(state), 32'd1);
        end
        check_val("acq_state",   32'(state),  32'd2);
        check_val("acq_offset",  32'(offset), 32'd12);
        check_val("acq_locked",  32'(locked), 32'd1);
        check_val("acq_pulses",  32'(adj_seen), 32'd3);

        // Snapshot in TRACK
        drive_cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        check_val("snap_v",   32'(snap_valid),  32'd1);
        check_val("snap_off", 32'(snap_offset), 32'd12);
        check_val("snap_st",  32'(snap_state),  32'd2);

        // Outliers: delta 60 > 12+32
        send(60, 1'b0);
        check_val("outl1_state", 32'(state), 32'd2);
        send(60, 1'b0);
        check_val("outl2_offset", 32'(offset), 32'd12);
        send(60, 1'b0);
        check_val("outl3_state",  32'(state),  32'd1);
        check_val("outl3_offset", 32'(offset), 32'd0);

        // Wrap: 3 - 250 = 9 (mod 256)
        send(5, 1'b0);
        check_val("wrap_pre", 32'(offset), 32'd5);
        drive_cycle(1'b0, 8'd3, 8'd250, 1'b1, 1'b0, 1'b0);
        check_val("wrap_offset", 32'(offset),        32'd9);
        check_val("wrap_adjust", 32'(offset_adjust), 32'd1);
        for (int i = 0; i < 14; i++) send((i == 5) ? 12 : i % 10, 1'b0);
        check_val("reacq_state", 32'(state), 32'd2);

        // Loss of stream
        quiet(LOSS - 1, 1'b1);
        check_val("loss_pre_state", 32'(state), 32'd2);
        quiet(1, 1'b1);
        check_val("loss_state",  32'(state),  32'd3);
        check_val("loss_locked", 32'(locked), 32'd0);
        check_val("loss_offset", 32'(offset), 32'd12);
        quiet(10, 1'b1);
        check_val("hold_offset", 32'(offset), 32'd12);
        send(3, 1'b1);
        check_val("hold_exit_state",  32'(state),  32'd1);
        check_val("hold_exit_offset", 32'(offset), 32'd12);
        for (int i = 0; i < 15; i++) send(i % 13, 1'b0);
        check_val("retrack_state", 32'(state), 32'd2);

        // Decay: no raises for DECAY edges
        adj_seen = 0;
        for (int i = 0; i < DECAY; i++) begin
            if (i % 1000 == 500) send(2, 1'b1);
            else drive_cycle(1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
            if (i == DECAY - 2) check_val("decay_pre", 32'(offset), 32'd12);
        end
        check_val("decay_offset", 32'(offset), 32'd11);
        check_val("decay_pulses", 32'(adj_seen), 32'd0);

        // In-window raise
        send(20, 1'b0);
        check_val("raise_offset", 32'(offset), 32'd20);

        // clear_req beats a simultaneous valid
        drive_cycle(1'b1, 8'd100, 8'd50, 1'b1, 1'b1, 1'b0);
        check_val("clr_state",  32'(state),  32'd0);
        check_val("clr_offset", 32'(offset), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [7:0] c;
            int         dd;
            c  = 8'($urandom_range(0, 255));
            dd = $urandom_range(0, 80);
            drive_cycle(1'($urandom_range(0, 1)), c, c - 8'(dd),
                        ($urandom_range(0, 2) == 0), ($urandom_range(0, 149) == 0),
                        ($urandom_range(0, 15) == 0));
        end

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
